// File: rtl/multicycle_control_if.sv
// Decode inputs and control outputs of the multicycle RISC-V controller.
// The slave modport is the controller side; master is the datapath/bench side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] ALU_control;
  logic [3:0] state;
  logic       illegal;

  modport slave (
    input  opcode, funct3, funct7b5, zero_flag, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, ALU_control, state, illegal
  );

  modport master (
    output opcode, funct3, funct7b5, zero_flag, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, ALU_control, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: state register plus sticky illegal flag;
// all control outputs are decoded combinationally from the state and inputs.
module multicycle_control (
  input logic                   clk,
  input logic                   reset,
  multicycle_control_if.slave   bus
);
  typedef enum logic [3:0] {
    StFetch = 4'd0, StDecode = 4'd1, StMemAdr = 4'd2, StMemRead = 4'd3,
    StMemWb = 4'd4, StMemWrite = 4'd5, StExecR = 4'd6, StExecI = 4'd7,
    StAluWb = 4'd8, StBranch = 4'd9, StJal = 4'd10, StJalr = 4'd11,
    StLui = 4'd12, StAuipc = 4'd13, StJlink = 4'd14, StTrap = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? 4'b1001 : 4'b0000;
      3'b001:  alu_op = 4'b0111;
      3'b010:  alu_op = 4'b0001;
      3'b011:  alu_op = 4'b0010;
      3'b100:  alu_op = 4'b0101;
      3'b101:  alu_op = 4'b1000;
      3'b110:  alu_op = 4'b0100;
      default: alu_op = 4'b0011;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 4'b0000;
    case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = bus.mem_ready;
        ir_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBr:            state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StExecR, StExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_control = alu_op(bus.funct3, (state_q == StExecR) && bus.funct7b5);
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        state_d   = StFetch;
        case (bus.funct3)
          3'b000:  alu_control = 4'b1010;
          3'b001:  alu_control = 4'b1011;
          3'b100:  alu_control = 4'b1100;
          3'b101:  alu_control = 4'b1110;
          3'b110:  alu_control = 4'b1101;
          3'b111:  alu_control = 4'b1111;
          default: state_d     = StTrap;
        endcase
        pc_write = bus.zero_flag && (state_d == StFetch);
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = StJlink;
      end
      StJlink: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StLui: begin
        alu_src_b   = 2'b01;
        alu_control = 4'b0110;
        state_d     = StAluWb;
      end
      StAuipc: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  // Write strobes are squashed for the whole reset cycle, including mid-access.
  assign bus.pc_write    = pc_write & ~reset;
  assign bus.ir_write    = ir_write & ~reset;
  assign bus.mem_write   = mem_write & ~reset;
  assign bus.reg_write   = reg_write & ~reset;
  assign bus.adr_src     = adr_src;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.ALU_control = alu_control;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction mix,
// checked against a per-instruction state-path and control-table model.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [6:0] LD = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011;
  localparam logic [6:0] II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

  typedef int q_t[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_illegal;
  int   cyc;
  logic [3:0] alu_tbl [8] = '{4'h0, 4'h7, 4'h1, 4'h2, 4'h5, 4'h8, 4'h4, 4'h3};
  logic [3:0] br_tbl  [8] = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hE, 4'hD, 4'hF};
  logic [6:0] ops     [9] = '{LD, SW, RR, II, BR, JL, JR, LU, AU};
  logic [2:0] br_f3   [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  // Sequence of states an instruction visits, FETCH first, ending before the next FETCH.
  function automatic q_t path_for(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      LD:      return '{0, 1, 2, 3, 4};
      SW:      return '{0, 1, 2, 5};
      RR:      return '{0, 1, 6, 8};
      II:      return '{0, 1, 7, 8};
      BR:      return (f3 == 3'd2 || f3 == 3'd3) ? '{0, 1, 9, 15} : '{0, 1, 9};
      JL:      return '{0, 1, 10, 8};
      JR:      return '{0, 1, 11, 14};
      LU:      return '{0, 1, 12, 8};
      AU:      return '{0, 1, 13, 8};
      default: return '{0, 1, 15};
    endcase
  endfunction

  function automatic int latency(input logic [6:0] op);
    if (op == LD) return 5;
    if (op == BR) return 3;
    return 4;
  endfunction

  // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu}
  function automatic logic [14:0] exp_out(input int st, input logic [2:0] f3, input logic f7,
                                           input logic zf, input logic mr);
    logic pc, adr, ir, mw, rw;
    logic [1:0] res, a, b;
    logic [3:0] alu;
    {pc, adr, ir, mw, rw} = '0;
    res = 2'b00; a = 2'b00; b = 2'b00; alu = 4'h0;
    case (st)
      0:  begin b = 2'b10; res = 2'b10; pc = mr; ir = mr; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6, 7: begin
        a = 2'b10;
        b = (st == 7) ? 2'b01 : 2'b00;
        alu = (f3 == 3'd0 && st == 6 && f7) ? 4'h9 : alu_tbl[f3];
      end
      8:  rw = 1'b1;
      9:  begin
        a = 2'b10;
        alu = br_tbl[f3];
        pc = (f3 == 3'd2 || f3 == 3'd3) ? 1'b0 : zf;
      end
      10: begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      11: begin a = 2'b10; b = 2'b01; res = 2'b10; pc = 1'b1; end
      12: begin b = 2'b01; alu = 4'h6; end
      13: begin a = 2'b01; b = 2'b01; end
      14: begin a = 2'b01; b = 2'b10; res = 2'b10; rw = 1'b1; end
      default: ;
    endcase
    return {pc, adr, ir, mw, rw, res, a, b, alu};
  endfunction

  task automatic do_cycle(input int exp_st, input logic mr, input logic rst);
    logic [14:0] e, got;
    bus.mem_ready = mr;
    reset = rst;
    @(negedge clk);
    e = exp_out(exp_st, bus.funct3, bus.funct7b5, bus.zero_flag, mr);
    if (rst) begin e[14] = 1'b0; e[12] = 1'b0; e[11] = 1'b0; e[10] = 1'b0; end
    got = {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
           bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.ALU_control};
    checks++;
    assert (bus.state === 4'(exp_st)) else begin
      errors++; $error("FAIL state: got %0d want %0d", bus.state, exp_st);
    end
    checks++;
    assert (bus.illegal === exp_illegal) else begin
      errors++; $error("FAIL illegal (st %0d): got %b want %b", exp_st, bus.illegal, exp_illegal);
    end
    checks++;
    assert (got === e) else begin
      errors++; $error("FAIL outputs (st %0d op %b f3 %0d): got %h want %h",
                       exp_st, bus.opcode, bus.funct3, got, e);
    end
    @(posedge clk);
    #1;
    if (rst) exp_illegal = 1'b0;
  endtask

  // Runs one instruction from FETCH; stops on entering TRAP without checking it.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zf, input bit rnd, input int stalls, output int cycles);
    q_t   p;
    int   idx = 0, n = 0, sc = 0, st;
    logic mr;
    p = path_for(op, f3);
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero_flag = zf;
    while (idx < p.size() && n < 100) begin
      st = p[idx];
      if (st == 15) break;
      mr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (st == 3 && sc < stalls) begin mr = 1'b0; sc++; end
      do_cycle(st, mr, 1'b0);
      n++;
      if (!((st == 0 || st == 3 || st == 5) && !mr)) begin
        idx++;
        if (idx < p.size() && p[idx] == 15) exp_illegal = 1'b1;
      end
    end
    if (n >= 100) begin
      checks++; errors++;
      $error("FAIL timeout: op %b stuck after %0d cycles", op, n);
    end
    cycles = n;
  endtask

  task automatic check_lat(input logic [6:0] op, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++; $error("FAIL latency op %b: got %0d want %0d", op, got, want);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    exp_illegal = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(0, 1'b1, 1'b1);

    run_instr(RR, 3'd0, 1'b0, 1'b0, 1'b0, 0, cyc);
    check_lat(RR, cyc, latency(RR));
    run_instr(RR, 3'd0, 1'b1, 1'b0, 1'b0, 0, cyc);
    run_instr(LD, 3'd2, 1'b0, 1'b0, 1'b0, 3, cyc);
    check_lat(LD, cyc, latency(LD) + 3);
    run_instr(BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, cyc);
    check_lat(BR, cyc, latency(BR));
    run_instr(BR, 3'd0, 1'b0, 1'b0, 1'b0, 0, cyc);
    run_instr(JR, 3'd0, 1'b0, 1'b0, 1'b0, 0, cyc);
    check_lat(JR, cyc, latency(JR));
    for (int i = 0; i < 9; i++) begin
      run_instr(ops[i], (ops[i] == BR) ? 3'd1 : 3'(i), 1'b0, 1'b1, 1'b0, 0, cyc);
      check_lat(ops[i], cyc, latency(ops[i]));
    end

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 8)];
      f3 = (op == BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom);
      run_instr(op, f3, 1'($urandom), 1'($urandom), 1'b1, 0, cyc);
    end

    // Reset while a store is waiting on memory.
    bus.opcode = SW; bus.funct3 = 3'd2;
    do_cycle(0, 1'b1, 1'b0);
    do_cycle(1, 1'b1, 1'b0);
    do_cycle(2, 1'b1, 1'b0);
    do_cycle(5, 1'b0, 1'b1);
    do_cycle(0, 1'b0, 1'b0);
    do_cycle(0, 1'b1, 1'b1);

    // Branch with unsupported funct3 traps.
    run_instr(BR, 3'd2, 1'b0, 1'b1, 1'b0, 0, cyc);
    do_cycle(15, 1'b1, 1'b0);
    do_cycle(15, 1'b1, 1'b1);

    // Unknown opcode traps and holds until reset.
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 0, cyc);
    for (int i = 0; i < 10; i++) begin
      bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom);
      bus.zero_flag = 1'($urandom);
      do_cycle(15, 1'($urandom), 1'b0);
    end
    do_cycle(15, 1'b1, 1'b1);
    bus.opcode = AU;
    do_cycle(0, 1'b1, 1'b0);
    do_cycle(1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
